fifo_word_reader: RTL and testbench

//   Read-side consumer for the 8-bit FIFO. Drains bytes via rd_en/buf_out/buf_empty and packs

---
 rtl/fifo_word_reader.sv | 112 +++++++++++
 tb/tb_fifo_word_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_reader.sv
// Drains an 8-bit FIFO and packs bytes little-endian into words for a valid/ready sink.
// A flush request emits whatever partial word is held so no byte is left stranded.
`timescale 1ns/1ps

module fifo_word_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = $clog2(BYTES_PER_WORD) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               buf_empty,
    input  logic [DATA_WIDTH-1:0]              buf_out,
    output logic                               rd_en,
    input  logic                               flush,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_out,
    output logic [CNT_W-1:0]                   word_bytes,
    output logic                               word_valid,
    input  logic                               word_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_OUT
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_PER_WORD);

    state_t                              r_state;
    state_t                              w_next;
    logic [CNT_W-1:0]                    r_count;
    logic                                r_flush_pend;
    logic [DATA_WIDTH*BYTES_PER_WORD-1:0] r_word;
    logic [CNT_W-1:0]                    w_cnt_inc;
    logic                                w_flush_any;

    assign w_cnt_inc   = r_count + 1'b1;
    assign w_flush_any = r_flush_pend | flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_flush_any && (r_count != '0))
                    w_next = S_OUT;
                else if (!buf_empty)
                    w_next = S_READ;
            end
            S_READ:  w_next = S_LATCH;
            S_LATCH: begin
                if (w_cnt_inc == FULL_CNT)
                    w_next = S_OUT;
                else if (w_flush_any)
                    w_next = S_OUT;
                else if (!buf_empty)
                    w_next = S_READ;
                else
                    w_next = S_IDLE;
            end
            S_OUT: begin
                if (word_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_flush_pend <= 1'b0;
            r_word       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_READ: begin
                    if (flush)
                        r_flush_pend <= 1'b1;
                end
                S_LATCH: begin
                    // Guard keeps the byte count from ever passing a full word.
                    if (r_count < FULL_CNT) begin
                        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                            if (r_count == CNT_W'(i))
                                r_word[i*DATA_WIDTH +: DATA_WIDTH] <= buf_out;
                        end
                        r_count <= w_cnt_inc;
                    end
                    if (flush)
                        r_flush_pend <= 1'b1;
                end
                S_OUT: begin
                    if (word_ready) begin
                        r_word       <= '0;
                        r_count      <= '0;
                        r_flush_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_en      = (r_state == S_READ);
    assign word_valid = (r_state == S_OUT);
    assign word_out   = r_word;
    assign word_bytes = r_count;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: behavioural FIFO, byte-stream scoreboard, directed and random stimulus.
`timescale 1ns/1ps

module tb_fifo_word_reader;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        buf_empty;
    logic [7:0]  buf_out;
    logic        rd_en;
    logic        flush;
    logic [31:0] word_out;
    logic [2:0]  word_bytes;
    logic        word_valid;
    logic        word_ready;

    logic        wr_en;
    logic [7:0]  wr_data;
    logic        buf_full;

    int total = 0;
    int bad   = 0;

    fifo_word_reader #(
        .DATA_WIDTH(8),
        .BYTES_PER_WORD(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .buf_empty(buf_empty),
        .buf_out(buf_out),
        .rd_en(rd_en),
        .flush(flush),
        .word_out(word_out),
        .word_bytes(word_bytes),
        .word_valid(word_valid),
        .word_ready(word_ready)
    );

    always #5 clk = ~clk;

    // FIFO model: buf_out updates on the edge that accepts a read.
    logic [7:0] mem [DEPTH];
    int         fifo_cnt, wp, rp;
    logic       do_rd, do_wr;

    assign buf_empty = (fifo_cnt == 0);
    assign buf_full  = (fifo_cnt == DEPTH);
    assign do_rd     = rd_en && !buf_empty;
    assign do_wr     = wr_en && !buf_full;

    always @(posedge clk) begin
        if (rst) begin
            fifo_cnt <= 0;
            wp       <= 0;
            rp       <= 0;
            buf_out  <= '0;
        end else begin
            if (do_rd) begin
                buf_out <= mem[rp];
                rp      <= (rp + 1) % DEPTH;
            end
            if (do_wr) begin
                mem[wp] <= wr_data;
                wp      <= (wp + 1) % DEPTH;
            end
            fifo_cnt <= fifo_cnt + int'(do_wr) - int'(do_rd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every accepted word is the next word_bytes bytes of the written stream.
    logic [7:0]  exp_q[$];
    logic [31:0] acc_q[$];
    int          accb_q[$];
    int          valid_cycles = 0;
    bit          flush_seen   = 0;
    bit          hold_pend    = 0;
    logic [31:0] held_word;
    logic [2:0]  held_bytes;

    always @(negedge clk) begin
        if (rst) begin
            flush_seen = 0;
            hold_pend  = 0;
        end else begin
            if (word_valid) valid_cycles++;
            chk("rd_while_out", {31'd0, rd_en & word_valid}, 32'd0);
            if (hold_pend) begin
                chk("hold_valid", {31'd0, word_valid}, 32'd1);
                chk("hold_word", word_out, held_word);
                chk("hold_bytes", {29'd0, word_bytes}, {29'd0, held_bytes});
            end
            if (flush && !word_valid) flush_seen = 1;
            if (word_valid && word_ready) begin
                automatic int          n   = int'(word_bytes);
                automatic logic [31:0] exp = '0;
                chk("bytes_range", {31'd0, (n >= 1 && n <= 4)}, 32'd1);
                if (n < 4) chk("partial_needs_flush", {31'd0, flush_seen}, 32'd1);
                for (int i = 0; i < n && i < 4; i++) begin
                    if (exp_q.size() > 0) exp[i*8 +: 8] = exp_q.pop_front();
                    else exp = 32'hxxxx_xxxx;
                end
                chk("word_data", word_out, exp);
                acc_q.push_back(word_out);
                accb_q.push_back(n);
                flush_seen = 0;
            end
            hold_pend  = word_valid && !word_ready;
            held_word  = word_out;
            held_bytes = word_bytes;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        step();
        if (!buf_full) begin
            wr_en   = 1'b1;
            wr_data = b;
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_flush();
        step();
        flush = 1'b1;
        step();
    endtask

    task automatic wait_acc(input int target, input int budget);
        int k = 0;
        while (acc_q.size() < target && k < budget) begin
            step();
            k++;
        end
        chk("wait_word", {31'd0, acc_q.size() >= target}, 32'd1);
    endtask

    task automatic clear_acc();
        acc_q.delete();
        accb_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, k, sum, n0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = '0;
        flush      = 1'b0;
        word_ready = 1'b0;

        // 1: reset with empty FIFO
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
            chk("rst_valid", {31'd0, word_valid}, 32'd0);
            chk("rst_word", word_out, 32'd0);
            chk("rst_bytes", {29'd0, word_bytes}, 32'd0);
        end
        rst = 1'b0;

        // 2: one full word with ready high
        word_ready = 1'b1;
        seen = 0;
        valid_cycles = 0;
        for (int i = 1; i <= 4; i++) begin
            push_byte(8'(i));
            if (rd_en) seen++;
        end
        k = 0;
        while (acc_q.size() < 1 && k < 60) begin
            step();
            if (rd_en) seen++;
            k++;
        end
        repeat (5) begin
            step();
            if (rd_en) seen++;
        end
        chk("t2_rd_pulses", 32'(seen), 32'd4);
        chk("t2_valid_cycles", 32'(valid_cycles), 32'd1);
        chk("t2_count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) begin
            chk("t2_word", acc_q[0], 32'h04030201);
            chk("t2_bytes", 32'(accb_q[0]), 32'd4);
        end

        // 3: backpressure holds the word and stops reads
        clear_acc();
        word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        k = 0;
        while (!word_valid && k < 60) begin
            step();
            k++;
        end
        chk("t3_valid", {31'd0, word_valid}, 32'd1);
        repeat (20) begin
            step();
            chk("t3_hold_word", word_out, 32'h04030201);
            chk("t3_no_read", {31'd0, rd_en}, 32'd0);
        end
        word_ready = 1'b1;
        wait_acc(2, 100);
        if (acc_q.size() >= 2) begin
            chk("t3_word0", acc_q[0], 32'h04030201);
            chk("t3_word1", acc_q[1], 32'h08070605);
        end

        // 4: flush of a partial word, then flush with nothing held
        clear_acc();
        push_byte(8'h0A);
        push_byte(8'h0B);
        push_byte(8'h0C);
        repeat (20) step();
        chk("t4_no_early_word", 32'(acc_q.size()), 32'd0);
        pulse_flush();
        wait_acc(1, 40);
        if (acc_q.size() > 0) begin
            chk("t4_word", acc_q[0], 32'h000C0B0A);
            chk("t4_bytes", 32'(accb_q[0]), 32'd3);
        end
        repeat (5) step();
        n0 = acc_q.size();
        valid_cycles = 0;
        pulse_flush();
        repeat (10) step();
        chk("t4_empty_flush_words", 32'(acc_q.size()), 32'(n0));
        chk("t4_empty_flush_valid", 32'(valid_cycles), 32'd0);

        // 5: reset in the LATCH cycle of the second byte
        clear_acc();
        push_byte(8'h01);
        push_byte(8'h02);
        seen = 0;
        k = 0;
        while (seen < 2 && k < 40) begin
            step();
            if (rd_en) seen++;
            k++;
        end
        chk("t5_two_reads", 32'(seen), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_rd_drop", {31'd0, rd_en}, 32'd0);
        chk("t5_word_clr", word_out, 32'd0);
        repeat (10) step();
        chk("t5_no_word", 32'(acc_q.size()), 32'd0);
        for (int i = 5; i <= 8; i++) push_byte(8'(i));
        wait_acc(1, 60);
        if (acc_q.size() > 0) chk("t5_word", acc_q[0], 32'h08070605);

        // 6: fill FIFO under backpressure, then drain
        clear_acc();
        word_ready = 1'b0;
        k = 0;
        while (!buf_full && k < 64) begin
            push_byte(8'($urandom));
            k++;
        end
        step();
        chk("t6_full", {31'd0, buf_full}, 32'd1);
        word_ready = 1'b1;
        wait_acc(5, 400);
        repeat (5) step();
        sum = 0;
        foreach (accb_q[i]) sum += accb_q[i];
        chk("t6_bytes_out", 32'(sum), 32'd20);
        chk("t6_stream_left", 32'(exp_q.size()), 32'd0);

        // Random traffic, backpressure and flushes against the scoreboard
        clear_acc();
        repeat (600) begin
            step();
            word_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) flush = 1'b1;
            if (!buf_full && $urandom_range(0, 1) == 1) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
            end
        end
        word_ready = 1'b1;
        repeat (80) step();
        pulse_flush();
        repeat (30) step();
        chk("rand_stream_left", 32'(exp_q.size()), 32'd0);
        chk("rand_idle_valid", {31'd0, word_valid}, 32'd0);
        chk("rand_fifo_empty", {31'd0, buf_empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
